// File: rtl/load_level_counter.sv
// Saturating up/down level counter with hysteretic zone FSM and optional
// sticky error flags (enabled by defining LOAD_LEVEL_ERR_FLAGS_EN).
module load_level_counter #(
   parameter int WIDTH     = 4,
   parameter int MAX_LEVEL = 15,
   parameter int HI_THRESH = 12,
   parameter int LO_THRESH = 3,
   parameter int HYST      = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             inc,
   input  logic             dec,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_err,
   output logic [WIDTH-1:0] level,
   output logic             full,
   output logic             empty,
   output logic [1:0]       zone,
   output logic             ovf_err,
   output logic             unf_err
);

   typedef enum logic [1:0] {
      Z_LOW  = 2'b00,
      Z_MID  = 2'b01,
      Z_HIGH = 2'b10,
      Z_ILL  = 2'b11
   } zone_e;

   localparam logic [WIDTH-1:0] MAX_L  = WIDTH'(MAX_LEVEL);
   localparam logic [WIDTH-1:0] HI_L   = WIDTH'(HI_THRESH);
   localparam logic [WIDTH-1:0] LO_L   = WIDTH'(LO_THRESH);
   localparam logic [WIDTH-1:0] UP_L   = WIDTH'(LO_THRESH + HYST);
   localparam logic [WIDTH-1:0] DOWN_L = WIDTH'(HI_THRESH - HYST);

   logic [WIDTH-1:0] level_q, level_d;
   zone_e            zone_q, zone_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_q <= '0;
         zone_q  <= Z_LOW;
      end else begin
         level_q <= level_d;
         zone_q  <= zone_d;
      end
   end

   always_comb begin
      level_d = level_q;
      if (en) begin
         if (load) begin
            level_d = (load_val > MAX_L) ? MAX_L : load_val;
         end else if (inc && !dec) begin
            if (level_q != MAX_L) level_d = level_q + 1'b1;
         end else if (dec && !inc) begin
            if (level_q != '0) level_d = level_q - 1'b1;
         end
      end
   end

   // Zone tracks the registered level, hence lags it by one edge.
   always_comb begin
      zone_d = zone_q;
      unique case (zone_q)
         Z_LOW: begin
            if (level_q >= HI_L)      zone_d = Z_HIGH;
            else if (level_q >= UP_L) zone_d = Z_MID;
            else                      zone_d = Z_LOW;
         end
         Z_MID: begin
            if (level_q >= HI_L)      zone_d = Z_HIGH;
            else if (level_q <= LO_L) zone_d = Z_LOW;
            else                      zone_d = Z_MID;
         end
         Z_HIGH: begin
            if (level_q <= LO_L)        zone_d = Z_LOW;
            else if (level_q <= DOWN_L) zone_d = Z_MID;
            else                        zone_d = Z_HIGH;
         end
         default: zone_d = Z_LOW;
      endcase
   end

   assign level = level_q;
   assign zone  = zone_q;
   assign full  = (level_q == MAX_L);
   assign empty = (level_q == '0);

`ifdef LOAD_LEVEL_ERR_FLAGS_EN
   logic ovf_ev, unf_ev;
   logic ovf_q, ovf_d;
   logic unf_q, unf_d;

   always_comb begin
      ovf_ev = 1'b0;
      unf_ev = 1'b0;
      if (en) begin
         if (load)               ovf_ev = (load_val > MAX_L);
         else if (inc && !dec)   ovf_ev = (level_q == MAX_L);
         else if (dec && !inc)   unf_ev = (level_q == '0);
      end
      // A new event outranks a clear in the same cycle.
      ovf_d = ovf_ev | (ovf_q & ~(en & clr_err));
      unf_d = unf_ev | (unf_q & ~(en & clr_err));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign ovf_err = ovf_q;
   assign unf_err = unf_q;
`else
   logic unused_clr;
   assign unused_clr = clr_err;
   assign ovf_err    = 1'b0;
   assign unf_err    = 1'b0;
`endif

endmodule

// File: tb/tb_load_level_counter.sv
// Bench for load_level_counter: directed scenarios plus randomized traffic
// against a behavioural model, on a default and a MAX_LEVEL=10 instance.
module tb_load_level_counter;

`ifdef LOAD_LEVEL_ERR_FLAGS_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   localparam int HI = 12;
   localparam int LO = 3;
   localparam int HY = 2;

   logic clk = 1'b0;
   logic reset, en, inc, dec, load, clr_err;
   logic [3:0] load_val;

   logic [3:0] lvl0, lvl1;
   logic       full0, full1, empty0, empty1;
   logic [1:0] zone0, zone1;
   logic       ovf0, ovf1, unf0, unf1;

   int n_checks = 0;
   int n_err    = 0;

   int MAXV[2] = '{15, 10};
   int m_lvl[2];
   int m_zone[2];
   bit m_ovf[2];
   bit m_unf[2];

   always #5 clk = ~clk;

   load_level_counter dut (
      .clk(clk), .reset(reset), .en(en), .inc(inc), .dec(dec),
      .load(load), .load_val(load_val), .clr_err(clr_err),
      .level(lvl0), .full(full0), .empty(empty0), .zone(zone0),
      .ovf_err(ovf0), .unf_err(unf0)
   );

   load_level_counter #(.MAX_LEVEL(10)) dut10 (
      .clk(clk), .reset(reset), .en(en), .inc(inc), .dec(dec),
      .load(load), .load_val(load_val), .clr_err(clr_err),
      .level(lvl1), .full(full1), .empty(empty1), .zone(zone1),
      .ovf_err(ovf1), .unf_err(unf1)
   );

   // 0=LOW 1=MID 2=HIGH
   function automatic int nzone(int z, int l);
      case (z)
         0: return (l >= HI) ? 2 : (l >= LO + HY) ? 1 : 0;
         1: return (l >= HI) ? 2 : (l <= LO) ? 0 : 1;
         2: return (l <= LO) ? 0 : (l <= HI - HY) ? 1 : 2;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_lvl[k] = 0; m_zone[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int nz;
         bit so, su;
         so = 0; su = 0;
         nz = nzone(m_zone[k], m_lvl[k]);
         if (en) begin
            if (load) begin
               if (int'(load_val) > MAXV[k]) begin
                  so = 1; m_lvl[k] = MAXV[k];
               end else m_lvl[k] = int'(load_val);
            end else if (inc && !dec) begin
               if (m_lvl[k] == MAXV[k]) so = 1; else m_lvl[k]++;
            end else if (dec && !inc) begin
               if (m_lvl[k] == 0) su = 1; else m_lvl[k]--;
            end
         end
         m_zone[k] = nz;
         if (ERR_EN) begin
            m_ovf[k] = so | (m_ovf[k] & !(en && clr_err));
            m_unf[k] = su | (m_unf[k] & !(en && clr_err));
         end
      end
   endtask

   // Inputs change at negedge; outputs are sampled at the following negedge.
   task automatic tick();
      @(posedge clk);
      if (reset) model_reset(); else model_step();
      @(negedge clk);
   endtask

   task automatic idle();
      en = 0; inc = 0; dec = 0; load = 0; load_val = '0; clr_err = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1; model_reset();
      tick();
      reset = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      idle();
      reset = 1; model_reset();
      #1;
      n_checks++;
      if (lvl0 !== 4'd0 || zone0 !== 2'b00 || empty0 !== 1'b1 ||
          full0 !== 1'b0 || ovf0 !== 1'b0 || unf0 !== 1'b0) begin
         n_err++;
         $display("FAIL reset_state got lvl=%0d zone=%b e=%b f=%b o=%b u=%b want 0 00 1 0 0 0",
                  lvl0, zone0, empty0, full0, ovf0, unf0);
      end
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_ramp();
      do_reset();
      en = 1; inc = 1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         n_checks++;
         if (lvl0 !== 4'((i > 15) ? 15 : i)) begin
            n_err++;
            $display("FAIL ramp_level step=%0d got %0d want %0d", i, lvl0, (i > 15) ? 15 : i);
         end
      end
      n_checks++;
      if (full0 !== 1'b1 || empty0 !== 1'b0) begin
         n_err++;
         $display("FAIL ramp_full got f=%b e=%b want 1 0", full0, empty0);
      end
      n_checks++;
      if (ovf0 !== ERR_EN) begin
         n_err++;
         $display("FAIL ramp_ovf got %b want %b", ovf0, ERR_EN);
      end
   endtask

   task automatic test_hold();
      en = 1; inc = 1; dec = 1;
      tick();
      n_checks++;
      if (lvl0 !== 4'd15) begin
         n_err++;
         $display("FAIL hold_incdec got %0d want 15", lvl0);
      end
      en = 0; inc = 0; dec = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (lvl0 !== 4'd15) begin
            n_err++;
            $display("FAIL hold_en0 cyc=%0d got %0d want 15", i, lvl0);
         end
      end
   endtask

   task automatic test_load();
      idle();
      en = 1; load = 1; load_val = 4'd9; inc = 1;
      tick();
      n_checks++;
      if (lvl0 !== 4'd9 || lvl1 !== 4'd9) begin
         n_err++;
         $display("FAIL load_prio got %0d/%0d want 9/9", lvl0, lvl1);
      end
      inc = 0; load_val = 4'd13;
      tick();
      n_checks++;
      if (lvl1 !== 4'd10 || full1 !== 1'b1 || lvl0 !== 4'd13) begin
         n_err++;
         $display("FAIL load_clamp got %0d f=%b /%0d want 10 f=1 /13", lvl1, full1, lvl0);
      end
      n_checks++;
      if (ovf1 !== ERR_EN) begin
         n_err++;
         $display("FAIL load_ovf got %b want %b", ovf1, ERR_EN);
      end
      idle();
   endtask

   task automatic test_hysteresis();
      do_reset();
      en = 1; inc = 1;
      for (int i = 1; i <= 12; i++) begin
         tick();
         n_checks++;
         if (lvl0 !== 4'(i) || zone0 !== ((i >= 6) ? 2'b01 : 2'b00)) begin
            n_err++;
            $display("FAIL hyst_up step=%0d got lvl=%0d zone=%b want %0d %b",
                     i, lvl0, zone0, i, (i >= 6) ? 2'b01 : 2'b00);
         end
      end
      inc = 0;
      tick();
      n_checks++;
      if (zone0 !== 2'b10) begin
         n_err++;
         $display("FAIL hyst_high got %b want 10", zone0);
      end
      dec = 1;
      for (int j = 1; j <= 10; j++) begin
         logic [1:0] ez;
         ez = (j <= 2) ? 2'b10 : (j <= 9) ? 2'b01 : 2'b00;
         tick();
         n_checks++;
         if (lvl0 !== 4'(12 - j) || zone0 !== ez) begin
            n_err++;
            $display("FAIL hyst_down step=%0d got lvl=%0d zone=%b want %0d %b",
                     j, lvl0, zone0, 12 - j, ez);
         end
      end
      idle();
   endtask

   task automatic test_async_reset();
      do_reset();
      en = 1; inc = 1;
      for (int i = 0; i < 7; i++) tick();
      n_checks++;
      if (lvl0 !== 4'd7 || zone0 !== 2'b01) begin
         n_err++;
         $display("FAIL areset_pre got lvl=%0d zone=%b want 7 01", lvl0, zone0);
      end
      #2;
      reset = 1; model_reset();
      #1;
      n_checks++;
      if (lvl0 !== 4'd0 || zone0 !== 2'b00 || ovf0 !== 1'b0 ||
          unf0 !== 1'b0 || empty0 !== 1'b1 || lvl1 !== 4'd0) begin
         n_err++;
         $display("FAIL areset_mid got lvl=%0d zone=%b o=%b u=%b e=%b want 0 00 0 0 1",
                  lvl0, zone0, ovf0, unf0, empty0);
      end
      reset = 0;
      tick();
      n_checks++;
      if (lvl0 !== 4'd1) begin
         n_err++;
         $display("FAIL areset_resume got %0d want 1", lvl0);
      end
      idle();
   endtask

   task automatic test_clear();
      do_reset();
      en = 1; dec = 1;
      tick();
      n_checks++;
      if (lvl0 !== 4'd0 || unf0 !== ERR_EN) begin
         n_err++;
         $display("FAIL clr_setup got lvl=%0d unf=%b want 0 %b", lvl0, unf0, ERR_EN);
      end
      clr_err = 1;
      tick();
      n_checks++;
      if (unf0 !== ERR_EN) begin
         n_err++;
         $display("FAIL clr_collide got %b want %b", unf0, ERR_EN);
      end
      dec = 0;
      tick();
      n_checks++;
      if (unf0 !== 1'b0) begin
         n_err++;
         $display("FAIL clr_alone got %b want 0", unf0);
      end
      idle();
   endtask

   task automatic test_random();
      logic [3:0] a_lvl[2];
      logic [1:0] a_zone[2];
      logic       a_full[2], a_empty[2], a_ovf[2], a_unf[2];
      do_reset();
      for (int c = 0; c < 400; c++) begin
         en       = ($urandom_range(0, 9) != 0);
         inc      = $urandom_range(0, 1);
         dec      = $urandom_range(0, 1);
         load     = ($urandom_range(0, 11) == 0);
         load_val = 4'($urandom_range(0, 15));
         clr_err  = ($urandom_range(0, 15) == 0);
         tick();
         a_lvl[0] = lvl0;  a_zone[0] = zone0; a_full[0] = full0;
         a_empty[0] = empty0; a_ovf[0] = ovf0; a_unf[0] = unf0;
         a_lvl[1] = lvl1;  a_zone[1] = zone1; a_full[1] = full1;
         a_empty[1] = empty1; a_ovf[1] = ovf1; a_unf[1] = unf1;
         for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (a_lvl[k] !== 4'(m_lvl[k]) || a_zone[k] !== 2'(m_zone[k]) ||
                a_full[k] !== (m_lvl[k] == MAXV[k]) || a_empty[k] !== (m_lvl[k] == 0) ||
                a_ovf[k] !== m_ovf[k] || a_unf[k] !== m_unf[k]) begin
               n_err++;
               $display("FAIL rand inst=%0d cyc=%0d got l=%0d z=%b f=%b e=%b o=%b u=%b want l=%0d z=%0d f=%b e=%b o=%b u=%b",
                        k, c, a_lvl[k], a_zone[k], a_full[k], a_empty[k], a_ovf[k], a_unf[k],
                        m_lvl[k], m_zone[k], m_lvl[k] == MAXV[k], m_lvl[k] == 0,
                        m_ovf[k], m_unf[k]);
            end
         end
      end
      idle();
   endtask

   initial begin
      idle();
      reset = 1;
      model_reset();
      test_reset();
      test_ramp();
      test_hold();
      test_load();
      test_hysteresis();
      test_async_reset();
      test_clear();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
